// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage widths (`PC_WIDTH, `DWIDTH) and FSM state encodings.
`ifndef IF_STAGE_DEFINES
`define IF_STAGE_DEFINES
`define PC_WIDTH 32
`define DWIDTH 32
`endif

package if_stage_pkg;
    localparam int PC_W = `PC_WIDTH;
    localparam int DW   = `DWIDTH;
    typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} if_state_e;
endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush clears valid only, load captures a new instruction.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [PC_W-1:0] pc_i,
    input  logic [PC_W-1:0] pc_plus4_i,
    input  logic [DW-1:0]   instr_i,
    output logic [PC_W-1:0] pc_o,
    output logic [PC_W-1:0] pc_plus4_o,
    output logic [DW-1:0]   instr_o,
    output logic            valid_o
);
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            pc_o       <= '0;
            pc_plus4_o <= '0;
            instr_o    <= '0;
            valid_o    <= 1'b0;
        end else if (flush_i) begin
            valid_o    <= 1'b0;
        end else if (load_i) begin
            pc_o       <= pc_i;
            pc_plus4_o <= pc_plus4_i;
            instr_o    <= instr_i;
            valid_o    <= 1'b1;
        end
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with FETCH/HOLD/DRAIN handshake FSM feeding if_id_reg.
// Define IF_MISALIGN_CHECK_EN to align branch targets and expose sticky o_misalign.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_pc,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [DW-1:0]   i_imem_instr,
    output logic [PC_W-1:0] o_pc,
    output logic [PC_W-1:0] o_pc_plus4,
    output logic [DW-1:0]   o_instr,
`ifdef IF_MISALIGN_CHECK_EN
    output logic            o_misalign,
`endif
    output logic            o_valid
);
    if_state_e       state_q;
    logic [PC_W-1:0] pc_q, pc_plus4, tgt;
    logic [DW-1:0]   buf_q;
    logic            load;

    assign pc_plus4    = pc_q + PC_W'(4);
    assign o_imem_req  = state_q == FETCH;
    assign o_imem_addr = pc_q;
    assign load        = !i_branch_taken && !i_stall &&
                         ((state_q == FETCH && i_imem_ack) || state_q == HOLD);

`ifdef IF_MISALIGN_CHECK_EN
    logic misalign_q;
    assign tgt        = {i_branch_pc[PC_W-1:2], 2'b00};
    assign o_misalign = misalign_q;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) misalign_q <= 1'b0;
        else if (i_branch_taken && |i_branch_pc[1:0]) misalign_q <= 1'b1;
`else
    assign tgt = i_branch_pc;
`endif

    // A redirect without an ack still owes the memory a response, so it must be drained.
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= '0;
        end else if (i_branch_taken) begin
            pc_q    <= tgt;
            state_q <= (state_q != HOLD && !i_imem_ack) ? DRAIN : FETCH;
        end else if (load) begin
            pc_q    <= pc_plus4;
            state_q <= FETCH;
        end else if (state_q == FETCH && i_imem_ack) begin
            buf_q   <= i_imem_instr;
            state_q <= HOLD;
        end else if (state_q == DRAIN && i_imem_ack) begin
            state_q <= FETCH;
        end

    if_id_reg u_if_id_reg (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .load_i     (load),
        .flush_i    (i_branch_taken),
        .pc_i       (pc_q),
        .pc_plus4_i (pc_plus4),
        .instr_i    (state_q == HOLD ? buf_q : i_imem_instr),
        .pc_o       (o_pc),
        .pc_plus4_o (o_pc_plus4),
        .instr_o    (o_instr),
        .valid_o    (o_valid)
    );
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 0, SHALL be the PC value loaded on reset.
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 i_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 i_stall  input  1  SHALL be the hazard-unit stall: hold PC and the IF/ID register.
REQ-005 i_branch_taken  input  1  SHALL be the branch-resolved flag (branch & compare from the branch adder stage).
REQ-006 i_branch_pc  input  `PC_WIDTH  SHALL be the branch target from the branch adder stage.
REQ-007 o_imem_req  output  1, o_imem_addr  output  `PC_WIDTH  SHALL be the instruction-memory request and its address.
REQ-008 i_imem_ack  input  1, i_imem_instr  input  `DWIDTH  SHALL be the memory response, valid only in the ack cycle.
REQ-009 o_pc, o_pc_plus4  output  `PC_WIDTH, o_instr  output  `DWIDTH, o_valid  output  1  SHALL be the IF/ID register toward decode.

Function
REQ-010 The FSM SHALL have exactly three states: FETCH (request outstanding), HOLD (instruction buffered during a stall) and DRAIN (discarding a stale response).
REQ-011 In FETCH, o_imem_req SHALL be 1 and o_imem_addr SHALL equal the PC; the address SHALL stay stable until ack.
REQ-012 FETCH, ack=1, stall=0, taken=0: IF/ID loads {PC, PC+4, instr}, o_valid=1, PC<=PC+4, remain FETCH.
REQ-013 FETCH, ack=1, stall=1, taken=0: the instruction SHALL be buffered, the PC held, and the FSM SHALL go to HOLD; the IF/ID register is unchanged.
REQ-014 In HOLD, o_imem_req SHALL be 0; when stall falls, IF/ID loads the buffered instruction, PC<=PC+4, next state FETCH.
REQ-015 FETCH, ack=0, stall=1: the IF/ID register SHALL hold its value; the request SHALL remain pending.
REQ-016 taken=1 (overrides stall) SHALL set o_valid<=0 (flush) and PC<=i_branch_pc.
REQ-017 If taken=1 in FETCH with ack=1, or in HOLD, the instruction SHALL be discarded; next state FETCH.
REQ-018 If taken=1 in FETCH with ack=0, next state SHALL be DRAIN.
REQ-019 In DRAIN, o_imem_req SHALL be 0; the next ack SHALL be discarded, then the FSM SHALL go to FETCH at the new PC.
REQ-020 A further taken=1 in DRAIN SHALL overwrite the PC only; the FSM SHALL stay in DRAIN.
REQ-021 PC+4 SHALL wrap modulo 2^`PC_WIDTH with no overflow flag.
REQ-022 stall=1 with no ack and not taken SHALL never change o_valid.

Reset
REQ-023 On i_rst: PC=RESET_PC, state=FETCH, o_valid=0, o_pc=o_pc_plus4=0, o_instr=0, buffer cleared.
REQ-024 Reset mid-fetch SHALL abandon the outstanding request; memory SHALL restart with reset.
REQ-025 After reset deassert, o_imem_req SHALL be 1 in the first cycle, with o_imem_addr=RESET_PC.

Configuration
REQ-026 With IF_MISALIGN_CHECK_EN defined: a taken target with nonzero bits [1:0] SHALL force those bits to 0 and set a sticky output o_misalign (1 bit, reset 0).
REQ-027 Without IF_MISALIGN_CHECK_EN: o_misalign SHALL be absent and targets SHALL be used unmodified.

Structure
REQ-028 `PC_WIDTH, `DWIDTH and the FSM state encodings SHALL live in the shared defines header.
REQ-029 The IF/ID register (load/flush/hold) SHALL be a sub-module named if_id_reg.

Verification
REQ-030 Reset, 1-cycle ack, instr 0xAAAA0001 -> o_pc=0, o_pc_plus4=4, o_valid=1; next addr=4.
REQ-031 ack with stall=1 for 3 cycles -> req=0 during HOLD; the IF/ID register loads the instruction one cycle after stall falls; PC=8.
REQ-032 taken=1 with target 0x40 while ack is pending -> o_valid=0, DRAIN; the late ack is discarded; the next request addr=0x40.
REQ-033 taken=1 with stall=1 -> flush wins: o_valid=0, PC=target.
REQ-034 PC=2^`PC_WIDTH-4, ack -> o_pc_plus4=0, next addr=0.
REQ-035 IF_MISALIGN_CHECK_EN, target 0x42 -> addr 0x40, o_misalign=1 until reset.
